timer_alarm: RTL and testbench
==============================

# timer_alarm

Compare/alarm stage that sits directly downstream of the 64-bit timer counter. It watches the live count, raises a sticky interrupt when the count reaches a programmed target, and in periodic mode re-arms itself by adding a fixed period. Overrun expiries that occur while the interrupt is still pending are counted. Its inputs are driven from the timer's software-register bank; its outputs feed that bank and the system interrupt line.

## Interface
Parameters:
- DATA_W, 32, register width; count, target and period are 2*DATA_W bits.
- MISS_W, 8, width of the saturating missed-expiry counter.

Ports:
- clk  input  1  system clock; the single clock of the block.
- rst  input  1  system reset, asynchronous, active-high.
- count_i  input  2*DATA_W  live count from the timer stage, treated as free-running modulo 2^(2*DATA_W).
- cmp_i  input  2*DATA_W  absolute target, loaded on arm_i.
- period_i  input  2*DATA_W  reload period, sampled on every expiry; 0 means one-shot.
- arm_i  input  1  single-cycle pulse: load target, enter ARMED.
- disarm_i  input  1  single-cycle pulse: return to IDLE.
- ack_i  input  1  single-cycle pulse: clear irq_o.
- irq_o  output  1  sticky alarm interrupt.
- armed_o  output  1  high in ARMED.
- target_o  output  2*DATA_W  current target register.
- missed_o  output  MISS_W  count of overrun expiries, saturating at all-ones.

## Operation
- State machine, 2 states:
  - IDLE: no compare is performed.
  - ARMED: compare against target_o every cycle.
- Reset values:
  - state = IDLE.
  - irq_o = 0, armed_o = 0.
  - target_o = 0, missed_o = 0.
- Hit detection is modular:
  - diff = count_i - target_o, computed at 2*DATA_W width with wrap.
  - hit = ARMED && diff[2*DATA_W-1] == 0.
  - The count is therefore at or past the target, valid while the target is less than 2^(2*DATA_W-1) ahead.
  - A counter wrap or a timer reset back to 0 needs no special case.
- Priority per cycle: disarm_i > arm_i > hit.
  - disarm_i: state to IDLE. irq_o, missed_o and target_o are held.
  - arm_i: target_o <= cmp_i, state to ARMED, missed_o <= 0. irq_o is held; software acks it separately. Re-arming while already ARMED is legal and simply reloads.
  - hit with period_i == 0: irq_o <= 1, state to IDLE.
  - hit with period_i != 0: irq_o <= 1, target_o <= target_o + period_i (modular), state stays ARMED.
- Overrun: a hit while irq_o is already 1 and ack_i is 0 increments missed_o, saturating.
- Catch-up: at most one period is added per cycle. If the count is several periods ahead, consecutive cycles hit, and each one after the first counts as missed while unacked.
- ack_i clears irq_o. If ack_i and a hit coincide, irq_o stays 1 and missed_o does not increment (the ack consumed the old event).
- armed_o reflects the registered state.

## Timing
- All outputs are registered; there are no combinational paths from input to output.
- Expiry latency: count_i == target at the clock edge ending cycle N, then irq_o = 1 from cycle N+1.
- Arming with a target already in the past (diff non-negative at arm): the first compare happens in the cycle after arm_i, so irq_o rises 2 cycles after the arm_i pulse.
- Periodic mode: the new target is visible on target_o in the cycle irq_o rises.
- Action latency:
  - ack_i: irq_o falls the next cycle.
  - disarm_i: armed_o falls the next cycle. A hit in the same cycle is discarded.
- Asynchronous rst mid-operation: all registers return to reset values immediately, and the block restarts in IDLE.
- Boundaries:
  - Target = 2^64-1 with period 1 hits across the counter wrap.
  - missed_o holds at 2^MISS_W-1.
  - period_i changes take effect at the next expiry only.

## Test plan
- One-shot: cmp_i=100, period_i=0, arm at count 10, count increments by 1 → irq_o rises the cycle after count_i=100, armed_o falls, target_o=100; ack → irq_o=0.
- Periodic with wrap: cmp_i=2^64-3, period_i=4 → hits at counts 2^64-3, 1, 5, each raising irq_o; target_o takes 1, then 5, then 9; armed_o stays 1.
- Overrun: period_i=10, ack never asserted for 5 expiries → missed_o=4, irq_o=1. Re-arm → missed_o=0. With MISS_W=2 and 6 unacked expiries → missed_o saturates at 3.
- Past target / catch-up: arm at count 1000 with cmp_i=0, period_i=100 → irq_o is 1 two cycles after arm; hits continue on consecutive cycles until target_o=1100 or beyond, and missed_o counts every hit after the first.
- Collisions:
  - ack_i coincident with a hit → irq_o stays 1, missed_o unchanged.
  - disarm_i coincident with a hit → state IDLE, no irq_o, no target update.
  - arm_i and disarm_i together → IDLE.
- Reset: assert rst asynchronously while ARMED with irq_o=1 and missed_o=3 → all outputs 0 immediately, without waiting for a clock edge, and the block stays idle after release until the next arm_i.

Source files
------------

// File: rtl/timer_alarm.sv
`default_nettype none
// ============================================================================
// Module   : timer_alarm
// Brief    : Compare/alarm stage for the 64-bit timer. It raises a sticky irq
//            at the target, with optional periodic re-arm and a saturating
//            overrun counter.
// Revision : 1.0 - initial release
// ============================================================================
module timer_alarm #(
    parameter int DATA_W = 32,
    parameter int MISS_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2*DATA_W-1:0]   count_i,
    input  logic [2*DATA_W-1:0]   cmp_i,
    input  logic [2*DATA_W-1:0]   period_i,
    input  logic                  arm_i,
    input  logic                  disarm_i,
    input  logic                  ack_i,
    output logic                  irq_o,
    output logic                  armed_o,
    output logic [2*DATA_W-1:0]   target_o,
    output logic [MISS_W-1:0]     missed_o
);

    localparam int                C_CNT_W    = 2 * DATA_W;
    localparam logic [MISS_W-1:0] C_MISS_MAX = {MISS_W{1'b1}};

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_ARMED = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_irq;
    logic                 w_irq_nxt;
    logic [C_CNT_W-1:0]   r_target;
    logic [C_CNT_W-1:0]   w_target_nxt;
    logic [MISS_W-1:0]    r_missed;
    logic [MISS_W-1:0]    w_missed_nxt;
    logic [C_CNT_W-1:0]   w_diff;
    logic                 w_hit;

    // Modular compare: a non-negative wrapped difference means the count is at
    // or past the target, so counter wrap and timer restarts need no special case.
    assign w_diff = count_i - r_target;
    assign w_hit  = (r_state == S_ARMED) && ($signed(w_diff) >= 0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_irq    <= 1'b0;
            r_target <= '0;
            r_missed <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_irq    <= w_irq_nxt;
            r_target <= w_target_nxt;
            r_missed <= w_missed_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_irq_nxt    = r_irq;
        w_target_nxt = r_target;
        w_missed_nxt = r_missed;

        if (ack_i) begin
            w_irq_nxt = 1'b0;
        end

        if (disarm_i) begin
            w_state_nxt = S_IDLE;
        end else if (arm_i) begin
            w_state_nxt  = S_ARMED;
            w_target_nxt = cmp_i;
            w_missed_nxt = '0;
        end else if (w_hit) begin
            w_irq_nxt = 1'b1;
            // An ack arriving with the hit consumes the old event, so no overrun.
            if (r_irq && !ack_i && (r_missed != C_MISS_MAX)) begin
                w_missed_nxt = r_missed + 1'b1;
            end
            if (period_i == '0) begin
                w_state_nxt = S_IDLE;
            end else begin
                w_target_nxt = r_target + period_i;
            end
        end
    end

    assign irq_o    = r_irq;
    assign armed_o  = (r_state == S_ARMED);
    assign target_o = r_target;
    assign missed_o = r_missed;

endmodule
`default_nettype wire

// File: tb/tb_timer_alarm.sv
`default_nettype none
// ============================================================================
// Module   : tb_timer_alarm
// Brief    : Scoreboard bench for timer_alarm (MISS_W=8 and MISS_W=2 instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_timer_alarm;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] count_i, cmp_i, period_i;
    logic        arm_i, disarm_i, ack_i;

    logic        irq_o, armed_o;
    logic [63:0] target_o;
    logic [7:0]  missed_o;
    logic        irq2_o, armed2_o;
    logic [63:0] target2_o;
    logic [1:0]  missed2_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    timer_alarm #(.DATA_W(32), .MISS_W(8)) u_dut (
        .clk(clk), .rst(rst), .count_i(count_i), .cmp_i(cmp_i),
        .period_i(period_i), .arm_i(arm_i), .disarm_i(disarm_i), .ack_i(ack_i),
        .irq_o(irq_o), .armed_o(armed_o), .target_o(target_o), .missed_o(missed_o)
    );

    timer_alarm #(.DATA_W(32), .MISS_W(2)) u_dut_m2 (
        .clk(clk), .rst(rst), .count_i(count_i), .cmp_i(cmp_i),
        .period_i(period_i), .arm_i(arm_i), .disarm_i(disarm_i), .ack_i(ack_i),
        .irq_o(irq2_o), .armed_o(armed2_o), .target_o(target2_o), .missed_o(missed2_o)
    );

    typedef struct packed {
        logic        irq;
        logic        armed;
        logic [63:0] target;
        logic [7:0]  missed;
        logic [1:0]  missed2;
    } exp_t;

    exp_t q_exp[$];

    logic        m_irq, m_armed;
    logic [63:0] m_target;
    logic [7:0]  m_missed;
    logic [1:0]  m_missed2;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_irq = 1'b0; m_armed = 1'b0; m_target = '0; m_missed = '0; m_missed2 = '0;
        q_exp.delete();
    endtask

    // Drive one cycle of stimulus, predict the registered outputs, compare after the edge.
    task automatic step(input logic [63:0] cnt, input logic a, input logic d, input logic k);
        logic [63:0] diff;
        logic        hit;
        logic        old_irq;
        exp_t        e;
        count_i = cnt; arm_i = a; disarm_i = d; ack_i = k;
        diff    = cnt - m_target;
        hit     = m_armed && !diff[63];
        old_irq = m_irq;
        if (k) m_irq = 1'b0;
        if (d) begin
            m_armed = 1'b0;
        end else if (a) begin
            m_armed = 1'b1; m_target = cmp_i; m_missed = '0; m_missed2 = '0;
        end else if (hit) begin
            m_irq = 1'b1;
            if (old_irq && !k) begin
                if (m_missed != 8'hFF) m_missed = m_missed + 8'd1;
                if (m_missed2 != 2'b11) m_missed2 = m_missed2 + 2'd1;
            end
            if (period_i == 64'd0) m_armed = 1'b0;
            else m_target = m_target + period_i;
        end
        e.irq = m_irq; e.armed = m_armed; e.target = m_target;
        e.missed = m_missed; e.missed2 = m_missed2;
        q_exp.push_back(e);
        @(posedge clk);
        #1;
        e = q_exp.pop_front();
        check("sb_irq",     irq_o,     e.irq);
        check("sb_armed",   armed_o,   e.armed);
        check("sb_target",  target_o,  e.target);
        check("sb_missed",  missed_o,  e.missed);
        check("sb_irq2",    irq2_o,    e.irq);
        check("sb_armed2",  armed2_o,  e.armed);
        check("sb_target2", target2_o, e.target);
        check("sb_missed2", missed2_o, e.missed2);
        arm_i = 1'b0; disarm_i = 1'b0; ack_i = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] cv;
        rst = 1'b1; count_i = '0; cmp_i = '0; period_i = '0;
        arm_i = 1'b0; disarm_i = 1'b0; ack_i = 1'b0;
        model_reset();
        @(posedge clk); #1;
        check("rst_irq", irq_o, 0);
        check("rst_armed", armed_o, 0);
        check("rst_target", target_o, 0);
        check("rst_missed", missed_o, 0);
        rst = 1'b0;

        // One-shot
        cmp_i = 64'd100; period_i = 64'd0;
        step(64'd10, 1'b1, 1'b0, 1'b0);
        for (int c = 11; c <= 105; c++) step(64'(c), 1'b0, 1'b0, 1'b0);
        check("oneshot_irq", irq_o, 1);
        check("oneshot_armed", armed_o, 0);
        check("oneshot_target", target_o, 64'd100);
        step(64'd106, 1'b0, 1'b0, 1'b1);
        check("oneshot_ack", irq_o, 0);

        // Periodic across the counter wrap
        cmp_i = 64'hFFFF_FFFF_FFFF_FFFD; period_i = 64'd4;
        step(64'hFFFF_FFFF_FFFF_FFF6, 1'b1, 1'b0, 1'b0);
        cv = 64'hFFFF_FFFF_FFFF_FFF7;
        repeat (18) begin
            step(cv, 1'b0, 1'b0, 1'b0);
            cv = cv + 64'd1;
        end
        check("wrap_target", target_o, 64'd9);
        check("wrap_armed", armed_o, 1);
        check("wrap_irq", irq_o, 1);
        check("wrap_missed", missed_o, 8'd2);
        // Disarm coincident with a hit at count 9, with ack
        step(64'd9, 1'b0, 1'b1, 1'b1);
        check("dis_hit_armed", armed_o, 0);
        check("dis_hit_irq", irq_o, 0);
        check("dis_hit_target", target_o, 64'd9);

        // Overrun and saturation
        cmp_i = 64'd10; period_i = 64'd10;
        step(64'd0, 1'b1, 1'b0, 1'b0);
        for (int c = 1; c <= 50; c++) step(64'(c), 1'b0, 1'b0, 1'b0);
        check("ovr_missed5", missed_o, 8'd4);
        check("ovr_irq", irq_o, 1);
        for (int c = 51; c <= 60; c++) step(64'(c), 1'b0, 1'b0, 1'b0);
        check("ovr_missed6", missed_o, 8'd5);
        check("ovr_sat2", missed2_o, 2'd3);
        cmp_i = 64'd1_000_000;
        step(64'd61, 1'b1, 1'b0, 1'b0);
        check("rearm_missed", missed_o, 0);
        check("rearm_irq_held", irq_o, 1);

        // Past target / catch-up
        cmp_i = 64'd0; period_i = 64'd100;
        step(64'd1000, 1'b1, 1'b0, 1'b1);
        check("past_irq_arm", irq_o, 0);
        step(64'd1000, 1'b0, 1'b0, 1'b0);
        check("past_irq_2cyc", irq_o, 1);
        repeat (11) step(64'd1000, 1'b0, 1'b0, 1'b0);
        check("catchup_target", target_o, 64'd1100);
        check("catchup_missed", missed_o, 8'd10);

        // Ack coincident with hit
        cmp_i = 64'd1002; period_i = 64'd5;
        step(64'd1001, 1'b1, 1'b0, 1'b0);
        step(64'd1002, 1'b0, 1'b0, 1'b1);
        check("ackhit_irq", irq_o, 1);
        check("ackhit_missed", missed_o, 0);
        check("ackhit_target", target_o, 64'd1007);
        step(64'd1007, 1'b0, 1'b0, 1'b0);
        check("after_ackhit_missed", missed_o, 8'd1);
        step(64'd1010, 1'b0, 1'b0, 1'b1);
        step(64'd1012, 1'b0, 1'b1, 1'b0);
        check("dis_hit2_irq", irq_o, 0);
        check("dis_hit2_target", target_o, 64'd1012);
        // Arm and disarm together
        cmp_i = 64'd5000;
        step(64'd1013, 1'b1, 1'b1, 1'b0);
        check("armdis_armed", armed_o, 0);
        check("armdis_target", target_o, 64'd1012);

        // Asynchronous reset mid-operation
        cmp_i = 64'd1990; period_i = 64'd1;
        step(64'd2000, 1'b1, 1'b0, 1'b0);
        repeat (4) step(64'd2000, 1'b0, 1'b0, 1'b0);
        check("prerst_missed", missed_o, 8'd3);
        check("prerst_irq", irq_o, 1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_irq", irq_o, 0);
        check("arst_armed", armed_o, 0);
        check("arst_target", target_o, 0);
        check("arst_missed", missed_o, 0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 2001; c <= 2005; c++) step(64'(c), 1'b0, 1'b0, 1'b0);
        check("postrst_armed", armed_o, 0);
        check("postrst_irq", irq_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
